pulse_interval_meter: RTL and testbench
=======================================

PULSE_INTERVAL_METER -- requirements
Module: pulse_interval_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the interval counter and result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, setting the maximum interval in m_clk cycles before a measurement is abandoned; legal range 2 to 2^CNT_W-1.
REQ-003 m_clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 m_rst_n  input  1  asynchronous active-low reset.
REQ-005 start_pulse  input  1  start marker from the generator stage; asynchronous to m_clk.
REQ-006 stop_pulse  input  1  stop marker from the generator stage; asynchronous to m_clk.
REQ-007 stats_clr  input  1  synchronous clear of the statistics registers.
REQ-008 interval  output  CNT_W  last completed interval in m_clk cycles.
REQ-009 interval_valid  output  1  one-cycle strobe marking a new interval value.
REQ-010 timeout  output  1  one-cycle strobe marking an abandoned measurement.
REQ-011 busy  output  1  high while a measurement is in progress.

Function
REQ-012 start_pulse and stop_pulse SHALL each pass through a two-flop synchronizer followed by a rising-edge detector; a detected edge is a one-cycle internal event.
REQ-013 Both paths SHALL have identical latency of 3 cycles from input edge to event, so the measured interval is unbiased.
REQ-014 FSM states SHALL be IDLE, COUNT and DONE.
REQ-015 IDLE -> COUNT on a start event; the counter is cleared in that cycle.
REQ-016 The counter SHALL increment by 1 every cycle in COUNT.
REQ-017 COUNT -> DONE on a stop event; the interval SHALL equal (stop event cycle - start event cycle).
REQ-018 DONE SHALL last exactly one cycle, asserting interval_valid with interval updated in the same cycle, then return to IDLE.
REQ-019 COUNT -> IDLE when the counter reaches TIMEOUT with no stop event, pulsing timeout for one cycle; interval SHALL hold its previous value.
REQ-020 Stop and timeout in the same cycle: stop SHALL win, giving a valid result of TIMEOUT.
REQ-021 A stop event in IDLE or DONE SHALL be ignored.
REQ-022 A start event in COUNT or DONE SHALL be ignored; there is no retrigger.
REQ-023 Simultaneous start and stop events in IDLE: start SHALL be taken and stop ignored.
REQ-024 busy SHALL be high exactly in COUNT.
REQ-025 interval SHALL hold its value until the next valid result.

Reset
REQ-026 Asserting m_rst_n low SHALL immediately force: state IDLE, counter 0, interval 0, interval_valid 0, timeout 0, busy 0, synchronizer and edge flops 0, and all statistics at their clear values.
REQ-027 Reset mid-COUNT SHALL discard the measurement without any strobe.
REQ-028 After deassertion, an input already high SHALL NOT produce an event until it falls and rises again.

Configuration
REQ-029 Macro PULSE_INTERVAL_METER_STATS_EN SHALL compile in the outputs meas_cnt (32), int_min (CNT_W), int_max (CNT_W) and to_cnt (16).
REQ-030 With the macro defined, on each interval_valid: meas_cnt SHALL increment, and int_min/int_max SHALL update.
- Clear values: int_min = all ones, int_max = 0.
- Counters meas_cnt and to_cnt SHALL saturate.
REQ-031 With the macro defined, on each timeout, to_cnt SHALL increment.
REQ-032 With the macro defined, stats_clr SHALL restore clear values next cycle; clear SHALL take priority over an update in the same cycle.
REQ-033 Without the macro, these outputs and registers SHALL be absent and stats_clr SHALL be ignored.

Verification
REQ-034 Start rising edge, stop rising edge 10 cycles later -> interval_valid one cycle, interval=10, busy high 10 cycles.
REQ-035 Start only, TIMEOUT=1000 -> timeout pulse 1000 cycles after start event, busy low, interval unchanged.
REQ-036 Second start 4 cycles into COUNT, stop at 10 -> interval=10 (retrigger ignored).
REQ-037 Start and stop rise in the same cycle while IDLE -> busy high, no result, timeout after TIMEOUT.
REQ-038 m_rst_n low at cycle 5 of COUNT -> all outputs 0 at once, no strobe; next start/stop pair 7 apart -> interval=7.
REQ-039 STATS_EN build, intervals 10, 3, 25 then stats_clr -> meas_cnt=3, min=3, max=25, then 0/all-ones/0.

Source files
------------

// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: measures the m_clk cycle count between a start marker
// and a stop marker, both asynchronous to m_clk. Each marker is synchronized
// and edge-detected through identical pipelines, so the measured interval is
// unbiased. A measurement that runs for TIMEOUT cycles is abandoned.
// Optional statistics (meas_cnt, int_min, int_max, to_cnt) are compiled in
// when the macro PULSE_INTERVAL_METER_STATS_EN is defined.
module pulse_interval_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             m_clk,
  input  logic             m_rst_n,
  input  logic             start_pulse,
  input  logic             stop_pulse,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] interval,
  output logic             interval_valid,
  output logic             timeout,
  output logic             busy
`ifdef PULSE_INTERVAL_METER_STATS_EN
  ,
  output logic [31:0]      meas_cnt,
  output logic [CNT_W-1:0] int_min,
  output logic [CNT_W-1:0] int_max,
  output logic [15:0]      to_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  // Bit 0 is the start path, bit 1 the stop path; both see identical logic.
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] armed_q, armed_d;
  logic [1:0] ev_q, ev_d;
  logic [1:0] settle_q, settle_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic start_ev, stop_ev;
  assign start_ev = ev_q[0];
  assign stop_ev  = ev_q[1];

  // Synchronizer, edge detector and arming: an edge only counts once the
  // synchronized input has been seen low after reset (settle_q marks when
  // sync_q first holds a post-reset sample), so a level already high at
  // reset release never fires.
  always_comb begin
    settle_d = {settle_q[0], 1'b1};
    meta_d   = {stop_pulse, start_pulse};
    sync_d   = meta_q;
    prev_d   = sync_q;
    armed_d  = armed_q | ({2{settle_q[1]}} & ~sync_q);
    ev_d     = sync_q & ~prev_q & armed_q;
  end

  // Synchronizer and event registers.
  // NOTE: async active-low reset belongs in the sensitivity list; every
  // sequential assignment is non-blocking so all flops update together.
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      settle_q <= '0;
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      ev_q     <= '0;
    end else begin
      settle_q <= settle_d;
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      armed_q  <= armed_d;
      ev_q     <= ev_d;
    end
  end

  // Measurement FSM next state. The counter is 0 in the first COUNT cycle,
  // so the elapsed event-to-event distance is cnt_q + 1; stop is tested
  // before timeout so a stop in the final cycle still yields TIMEOUT.
  // NOTE: every output of this block gets a default first, so no latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    interval_d = interval_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (stop_ev) begin
          state_d    = DONE;
          interval_d = cnt_q + CNT_W'(1);
          valid_d    = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COUNT);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = valid_q;
  assign timeout        = timeout_q;
  assign busy           = busy_q;

`ifdef PULSE_INTERVAL_METER_STATS_EN
  logic [31:0]      meas_cnt_q, meas_cnt_d;
  logic [CNT_W-1:0] int_min_q, int_min_d;
  logic [CNT_W-1:0] int_max_q, int_max_d;
  logic [15:0]      to_cnt_q, to_cnt_d;

  // Statistics update on each result strobe; clear wins over any update.
  always_comb begin
    meas_cnt_d = meas_cnt_q;
    int_min_d  = int_min_q;
    int_max_d  = int_max_q;
    to_cnt_d   = to_cnt_q;
    if (stats_clr) begin
      meas_cnt_d = '0;
      int_min_d  = '1;
      int_max_d  = '0;
      to_cnt_d   = '0;
    end else begin
      if (valid_q) begin
        if (meas_cnt_q != '1)       meas_cnt_d = meas_cnt_q + 32'd1;
        if (interval_q < int_min_q) int_min_d  = interval_q;
        if (interval_q > int_max_q) int_max_d  = interval_q;
      end
      if (timeout_q && (to_cnt_q != '1)) to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      meas_cnt_q <= '0;
      int_min_q  <= '1;
      int_max_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      meas_cnt_q <= meas_cnt_d;
      int_min_q  <= int_min_d;
      int_max_q  <= int_max_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign meas_cnt = meas_cnt_q;
  assign int_min  = int_min_q;
  assign int_max  = int_max_q;
  assign to_cnt   = to_cnt_q;
`else
  // Statistics are not built; the clear input has no function.
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
`endif

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Self-checking bench for pulse_interval_meter. Expected strobes (kind,
// interval value, sample cycle) are queued when stimulus is driven and
// compared as the DUT raises interval_valid or timeout.
module tb_pulse_interval_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  // Input rise sampled at edge c+1, event after edge c+3, registered
  // strobe after edge c+4: strobe seen at cycle c + distance + LAT.
  localparam int LAT     = 4;

  logic             clk;
  logic             rst_n;
  logic             start_pulse;
  logic             stop_pulse;
  logic             stats_clr;
  logic [CNT_W-1:0] interval;
  logic             interval_valid;
  logic             timeout;
  logic             busy;
`ifdef PULSE_INTERVAL_METER_STATS_EN
  logic [31:0]      meas_cnt;
  logic [CNT_W-1:0] int_min;
  logic [CNT_W-1:0] int_max;
  logic [15:0]      to_cnt;
`endif

  pulse_interval_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .m_clk          (clk),
    .m_rst_n        (rst_n),
    .start_pulse    (start_pulse),
    .stop_pulse     (stop_pulse),
    .stats_clr      (stats_clr),
    .interval       (interval),
    .interval_valid (interval_valid),
    .timeout        (timeout),
    .busy           (busy)
`ifdef PULSE_INTERVAL_METER_STATS_EN
    ,
    .meas_cnt       (meas_cnt),
    .int_min        (int_min),
    .int_max        (int_max),
    .to_cnt         (to_cnt)
`endif
  );

  typedef struct {
    bit is_to;
    int iv;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   busy_cyc;
  int   last_iv;
  int   n_pass;
  int   n_total;
  logic [CNT_W-1:0] all_ones;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Scoreboard monitor: pops an expectation on every strobe, and flags
  // any expectation whose cycle has passed without a strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (interval_valid || timeout) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {62'd0, interval_valid, timeout}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_kind", {62'd0, interval_valid, timeout}, e.is_to ? 64'd1 : 64'd2);
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_interval", interval, e.iv);
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        check("missing_strobe", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start rise, then stop rise d cycles later; optional second start
  // rise 4 cycles in, which must be ignored.
  task automatic run_pair(input int d, input bit retrig);
    int   c;
    exp_t e;
    @(negedge clk);
    c = cyc;
    start_pulse = 1'b1;
    e.is_to = 1'b0; e.iv = d; e.cyc = c + d + LAT;
    sb.push_back(e);
    last_iv = d;
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      if (i == 2) start_pulse = 1'b0;
      if (retrig && i == 4) start_pulse = 1'b1;
      if (retrig && i == 6) start_pulse = 1'b0;
      if (i == d) stop_pulse = 1'b1;
    end
    nc(2);
    stop_pulse = 1'b0;
    nc(8);
  endtask

  // Start alone (or start and stop together) runs into the timeout.
  task automatic run_timeout(input bit with_stop);
    int   c;
    exp_t e;
    @(negedge clk);
    c = cyc;
    start_pulse = 1'b1;
    if (with_stop) stop_pulse = 1'b1;
    e.is_to = 1'b1; e.iv = last_iv; e.cyc = c + TIMEOUT + LAT;
    sb.push_back(e);
    nc(3);
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    nc(3);
    check(with_stop ? "busy_after_start_stop" : "busy_after_start", busy, 1);
    nc(TIMEOUT + 5);
    check(with_stop ? "idle_after_timeout2" : "idle_after_timeout", busy, 0);
  endtask

  initial begin
    int c;
    all_ones    = '1;
    cyc         = 0;
    busy_cyc    = 0;
    last_iv     = 0;
    n_pass      = 0;
    n_total     = 0;
    stats_clr   = 1'b0;
    // Both markers already high through reset: no event may follow.
    start_pulse = 1'b1;
    stop_pulse  = 1'b1;
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_interval", interval, 0);
    check("rst_valid", interval_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
`ifdef PULSE_INTERVAL_METER_STATS_EN
    check("rst_meas_cnt", meas_cnt, 0);
    check("rst_int_min", int_min, all_ones);
    check("rst_int_max", int_max, 0);
    check("rst_to_cnt", to_cnt, 0);
`endif
    nc(3);
    rst_n = 1'b1;
    nc(20);
    check("no_event_high_at_reset", busy, 0);
    start_pulse = 1'b0;
    stop_pulse  = 1'b0;
    nc(6);

    // Basic measurement of 10 cycles, busy high exactly 10 cycles.
    busy_cyc = 0;
    run_pair(10, 1'b0);
    check("interval_10", interval, 10);
    check("busy_cycles_10", busy_cyc, 10);

    run_pair(3, 1'b0);
    check("interval_3", interval, 3);

    // Retrigger ignored.
    run_pair(10, 1'b1);
    check("interval_retrig", interval, 10);

    // Timeout; interval holds.
    run_timeout(1'b0);
    check("interval_held_timeout", interval, 10);

    // Stop alone in IDLE is ignored.
    stop_pulse = 1'b1;
    nc(3);
    stop_pulse = 1'b0;
    nc(10);
    check("stop_in_idle_busy", busy, 0);

    // Start and stop together: start taken, runs to timeout.
    run_timeout(1'b1);

    // Stop in the timeout cycle wins.
    run_pair(TIMEOUT, 1'b0);
    check("interval_stop_wins", interval, TIMEOUT);

`ifdef PULSE_INTERVAL_METER_STATS_EN
    check("stats_meas_cnt_run", meas_cnt, 4);
    check("stats_to_cnt_run", to_cnt, 2);
    check("stats_min_run", int_min, 3);
    check("stats_max_run", int_max, TIMEOUT);
`endif

    // Reset in COUNT cycle 5: outputs clear at once, no strobe.
    @(negedge clk);
    c = cyc;
    start_pulse = 1'b1;
    nc(2);
    start_pulse = 1'b0;
    nc(LAT + 5 - 2);
    check("busy_before_mid_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_interval", interval, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_strobes", {interval_valid, timeout}, 0);
    last_iv = 0;
    nc(3);
    rst_n = 1'b1;
    nc(6);
    run_pair(7, 1'b0);
    check("interval_after_reset", interval, 7);

`ifdef PULSE_INTERVAL_METER_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("clr_meas_cnt", meas_cnt, 0);
    check("clr_int_min", int_min, all_ones);
    run_pair(10, 1'b0);
    run_pair(3, 1'b0);
    run_pair(25, 1'b0);
    check("stats_meas_cnt", meas_cnt, 3);
    check("stats_int_min", int_min, 3);
    check("stats_int_max", int_max, 25);
    check("stats_to_cnt", to_cnt, 0);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("clr2_meas_cnt", meas_cnt, 0);
    check("clr2_int_min", int_min, all_ones);
    check("clr2_int_max", int_max, 0);
`endif

    nc(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
